// File: rtl/ascon_phase_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ascon_phase_ctrl_if                                          |
// | Description : Handshake bundle between the Ascon phase sequencer, its      |
// |               host, the permutation core and the datapath strobes.         |
// |               The abort signal exists only when ASCON_ABORT_EN is defined. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface ascon_phase_ctrl_if;
  logic       start;
  logic [7:0] ad_blocks;
  logic [7:0] pt_blocks;
  logic       perm_ready;
`ifdef ASCON_ABORT_EN
  logic       abort;
`endif
  logic       perm_start;
  logic [3:0] perm_rounds;
  logic [2:0] phase;
  logic [7:0] blk_idx;
  logic       load_key;
  logic       absorb_ad;
  logic       absorb_pt;
  logic       dom_sep;
  logic       tag_valid;
  logic       busy;

  // Host / permutation-core side
  modport master (
`ifdef ASCON_ABORT_EN
    output abort,
`endif
    output start, ad_blocks, pt_blocks, perm_ready,
    input  perm_start, perm_rounds, phase, blk_idx,
    input  load_key, absorb_ad, absorb_pt, dom_sep, tag_valid, busy
  );

  // Sequencer side
  modport slave (
`ifdef ASCON_ABORT_EN
    input  abort,
`endif
    input  start, ad_blocks, pt_blocks, perm_ready,
    output perm_start, perm_rounds, phase, blk_idx,
    output load_key, absorb_ad, absorb_pt, dom_sep, tag_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/ascon_phase_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ascon_phase_ctrl                                             |
// | Description : Phase sequencer for one Ascon encryption: INIT, AD blocks,   |
// |               PT blocks, FINAL and TAG. Launches the permutation core with |
// |               the proper round count and emits one-cycle datapath strobes. |
// |               All outputs are registered. Optional ASCON_ABORT_EN adds an  |
// |               abort input that drops any active operation back to IDLE.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module ascon_phase_ctrl #(
  parameter int A = 12,  // rounds for initialization / finalization
  parameter int B = 6    // rounds for intermediate AD / PT permutations
) (
  input  wire logic          clk,
  input  wire logic          rst,
  ascon_phase_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_AD    = 3'd2,
    S_PT    = 3'd3,
    S_FINAL = 3'd4,
    S_TAG   = 3'd5
  } phase_t;

  localparam logic [3:0] C_ROUNDS_A = 4'(A);
  localparam logic [3:0] C_ROUNDS_B = 4'(B);

  phase_t     r_phase,       w_phase;
  logic [7:0] r_blk_idx,     w_blk_idx;
  logic [7:0] r_ad_cnt,      w_ad_cnt;
  logic [7:0] r_pt_cnt,      w_pt_cnt;
  logic       r_pending,     w_pending;
  logic       r_perm_start,  w_perm_start;
  logic [3:0] r_perm_rounds, w_perm_rounds;
  logic       r_load_key,    w_load_key;
  logic       r_absorb_ad,   w_absorb_ad;
  logic       r_absorb_pt,   w_absorb_pt;
  logic       r_dom_sep,     w_dom_sep;
  logic       r_tag_valid,   w_tag_valid;
  logic       r_busy,        w_busy;
  logic       w_enter_pt;
  logic       w_present_pt;
  logic       w_done;

  // perm_ready only counts as completion while a launch is outstanding
  assign w_done = bus.perm_ready && r_pending;

  // Next-state and next-output computation; every output is re-registered
  always_comb begin
    w_phase       = r_phase;
    w_blk_idx     = r_blk_idx;
    w_ad_cnt      = r_ad_cnt;
    w_pt_cnt      = r_pt_cnt;
    w_pending     = r_pending;
    w_perm_start  = 1'b0;
    w_perm_rounds = 4'd0;
    w_load_key    = 1'b0;
    w_absorb_ad   = 1'b0;
    w_absorb_pt   = 1'b0;
    w_dom_sep     = 1'b0;
    w_tag_valid   = 1'b0;
    w_busy        = 1'b0;
    w_enter_pt    = 1'b0;
    w_present_pt  = 1'b0;

    case (r_phase)
      S_IDLE: begin
        if (bus.start) begin
          w_phase       = S_INIT;
          w_ad_cnt      = bus.ad_blocks;
          // An empty plaintext still needs one (padded) block
          w_pt_cnt      = (bus.pt_blocks == 8'd0) ? 8'd1 : bus.pt_blocks;
          w_blk_idx     = 8'd0;
          w_load_key    = 1'b1;
          w_perm_start  = 1'b1;
          w_perm_rounds = C_ROUNDS_A;
          w_pending     = 1'b1;
        end
      end

      S_INIT: begin
        if (w_done) begin
          w_pending = 1'b0;
          w_blk_idx = 8'd0;
          if (r_ad_cnt != 8'd0) begin
            w_phase       = S_AD;
            w_absorb_ad   = 1'b1;
            w_perm_start  = 1'b1;
            w_perm_rounds = C_ROUNDS_B;
            w_pending     = 1'b1;
          end else begin
            w_enter_pt = 1'b1;
          end
        end
      end

      S_AD: begin
        if (w_done) begin
          w_pending = 1'b0;
          if (r_blk_idx < (r_ad_cnt - 8'd1)) begin
            w_blk_idx     = r_blk_idx + 8'd1;
            w_absorb_ad   = 1'b1;
            w_perm_start  = 1'b1;
            w_perm_rounds = C_ROUNDS_B;
            w_pending     = 1'b1;
          end else begin
            w_blk_idx  = 8'd0;
            w_enter_pt = 1'b1;
          end
        end
      end

      S_PT: begin
        if (r_pending) begin
          // Non-last block in flight: advance once its permutation completes
          if (bus.perm_ready) begin
            w_pending    = 1'b0;
            w_blk_idx    = r_blk_idx + 8'd1;
            w_present_pt = 1'b1;
          end
        end else begin
          // Last block was absorbed without a permutation: finalize now
          w_phase       = S_FINAL;
          w_blk_idx     = 8'd0;
          w_load_key    = 1'b1;
          w_perm_start  = 1'b1;
          w_perm_rounds = C_ROUNDS_A;
          w_pending     = 1'b1;
        end
      end

      S_FINAL: begin
        if (w_done) begin
          w_pending   = 1'b0;
          w_phase     = S_TAG;
          w_tag_valid = 1'b1;
        end
      end

      S_TAG: begin
        w_phase = S_IDLE;
      end

      default: begin
        w_phase   = S_IDLE;
        w_pending = 1'b0;
        w_blk_idx = 8'd0;
      end
    endcase

    // First PT block is presented together with the domain separation bit
    if (w_enter_pt) begin
      w_phase      = S_PT;
      w_dom_sep    = 1'b1;
      w_present_pt = 1'b1;
    end

    // Presenting a PT block: only non-last blocks are followed by a permutation
    if (w_present_pt) begin
      w_absorb_pt = 1'b1;
      if (w_blk_idx < (r_pt_cnt - 8'd1)) begin
        w_perm_start  = 1'b1;
        w_perm_rounds = C_ROUNDS_B;
        w_pending     = 1'b1;
      end
    end

    w_busy = (w_phase != S_IDLE);

`ifdef ASCON_ABORT_EN
    // Abort discards everything, including any outstanding permutation
    if (bus.abort && (r_phase != S_IDLE)) begin
      w_phase       = S_IDLE;
      w_blk_idx     = 8'd0;
      w_ad_cnt      = 8'd0;
      w_pt_cnt      = 8'd0;
      w_pending     = 1'b0;
      w_perm_start  = 1'b0;
      w_perm_rounds = 4'd0;
      w_load_key    = 1'b0;
      w_absorb_ad   = 1'b0;
      w_absorb_pt   = 1'b0;
      w_dom_sep     = 1'b0;
      w_tag_valid   = 1'b0;
      w_busy        = 1'b0;
    end
`endif
  end

  // State and output registers; reset wins over every input
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase       <= S_IDLE;
      r_blk_idx     <= 8'd0;
      r_ad_cnt      <= 8'd0;
      r_pt_cnt      <= 8'd0;
      r_pending     <= 1'b0;
      r_perm_start  <= 1'b0;
      r_perm_rounds <= 4'd0;
      r_load_key    <= 1'b0;
      r_absorb_ad   <= 1'b0;
      r_absorb_pt   <= 1'b0;
      r_dom_sep     <= 1'b0;
      r_tag_valid   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_phase       <= w_phase;
      r_blk_idx     <= w_blk_idx;
      r_ad_cnt      <= w_ad_cnt;
      r_pt_cnt      <= w_pt_cnt;
      r_pending     <= w_pending;
      r_perm_start  <= w_perm_start;
      r_perm_rounds <= w_perm_rounds;
      r_load_key    <= w_load_key;
      r_absorb_ad   <= w_absorb_ad;
      r_absorb_pt   <= w_absorb_pt;
      r_dom_sep     <= w_dom_sep;
      r_tag_valid   <= w_tag_valid;
      r_busy        <= w_busy;
    end
  end

  assign bus.phase       = r_phase;
  assign bus.blk_idx     = r_blk_idx;
  assign bus.perm_start  = r_perm_start;
  assign bus.perm_rounds = r_perm_rounds;
  assign bus.load_key    = r_load_key;
  assign bus.absorb_ad   = r_absorb_ad;
  assign bus.absorb_pt   = r_absorb_pt;
  assign bus.dom_sep     = r_dom_sep;
  assign bus.tag_valid   = r_tag_valid;
  assign bus.busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ascon_phase_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ascon_phase_ctrl                                          |
// | Description : Self-checking bench for ascon_phase_ctrl. A permutation-core |
// |               responder with random latency and stray perm_ready pulses    |
// |               drives the DUT; observed round/strobe sequences are checked  |
// |               against sequences derived from block counts. Abort scenarios |
// |               are included when ASCON_ABORT_EN is defined.                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_ascon_phase_ctrl;
  localparam int A = 12;
  localparam int B = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ascon_phase_ctrl_if bus ();

  ascon_phase_ctrl #(.A(A), .B(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Monitor / responder state
  int           q_rounds[$];
  logic [9:0]   q_ev[$];     // {kind, blk}: 0=absorb_ad 1=absorb_pt 2=dom_sep
  int           n_load, n_tag, n_strobe, viol;
  int           resp_cd  = 0;
  int           resp_min = 1;
  int           resp_max = 1;
  bit           spur_en  = 1'b0;

  // Permutation-core responder and strobe monitor, evaluated on the falling edge
  initial begin
    bus.perm_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.perm_ready = 1'b0;
      if (resp_cd > 0) begin
        resp_cd--;
        if (resp_cd == 0) bus.perm_ready = 1'b1;
      end
      if (bus.perm_start) begin
        if (resp_cd > 0) viol++;
        resp_cd = int'($urandom_range(resp_min, resp_max));
        q_rounds.push_back(int'(bus.perm_rounds));
      end else if (bus.perm_rounds != 4'd0) begin
        viol++;
      end
      if (spur_en && resp_cd == 0 && !bus.perm_ready && !bus.perm_start &&
          $urandom_range(0, 3) == 0)
        bus.perm_ready = 1'b1;
      if (bus.load_key) n_load++;
      if (bus.tag_valid) begin
        n_tag++;
        if (bus.phase != 3'd5) viol++;
      end
      if (bus.absorb_ad) begin
        q_ev.push_back({2'd0, bus.blk_idx});
        if (bus.phase != 3'd2) viol++;
      end
      if (bus.dom_sep) begin
        q_ev.push_back({2'd2, bus.blk_idx});
        if (bus.phase != 3'd3) viol++;
      end
      if (bus.absorb_pt) begin
        q_ev.push_back({2'd1, bus.blk_idx});
        if (bus.phase != 3'd3) viol++;
      end
      n_strobe += int'(bus.load_key) + int'(bus.absorb_ad) + int'(bus.absorb_pt) +
                  int'(bus.dom_sep) + int'(bus.tag_valid) + int'(bus.perm_start);
      if (bus.busy !== (bus.phase != 3'd0)) viol++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    q_rounds.delete();
    q_ev.delete();
    n_load   = 0;
    n_tag    = 0;
    n_strobe = 0;
    viol     = 0;
  endtask

  function automatic logic [26:0] out_vec();
    return {bus.perm_start, bus.perm_rounds, bus.phase, bus.blk_idx, bus.load_key,
            bus.absorb_ad, bus.absorb_pt, bus.dom_sep, bus.tag_valid, bus.busy};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1;
    bus.ad_blocks = 8'd5;
    bus.pt_blocks = 8'd5;
    tick();
    tick();
    checks++;
    if (out_vec() !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", out_vec());
    end
    rst = 1'b0;
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.phase !== 3'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority_start: phase %0d busy %0d expected 0 0", bus.phase, bus.busy);
    end
  endtask

  task automatic test_minimal();
    resp_min = 1;
    resp_max = 1;
    spur_en  = 1'b0;
    clear_mon();
    bus.ad_blocks = 8'd0;
    bus.pt_blocks = 8'd1;
    bus.start     = 1'b1;        // cycle 0
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) bus.start = 1'b0;
      case (c)
        1: begin
          checks++;
          if ({bus.phase, bus.load_key, bus.perm_start, bus.perm_rounds} !== {3'd1, 1'b1, 1'b1, 4'd12}) begin
            errors++;
            $display("FAIL min_c1: phase %0d lk %0d ps %0d rounds %0d expected 1 1 1 12",
                     bus.phase, bus.load_key, bus.perm_start, bus.perm_rounds);
          end
        end
        3: begin
          checks++;
          if ({bus.phase, bus.dom_sep, bus.absorb_pt, bus.perm_start} !== {3'd3, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL min_c3: phase %0d ds %0d apt %0d ps %0d expected 3 1 1 0",
                     bus.phase, bus.dom_sep, bus.absorb_pt, bus.perm_start);
          end
        end
        4: begin
          checks++;
          if ({bus.phase, bus.perm_start, bus.perm_rounds, bus.load_key} !== {3'd4, 1'b1, 4'd12, 1'b1}) begin
            errors++;
            $display("FAIL min_c4: phase %0d ps %0d rounds %0d lk %0d expected 4 1 12 1",
                     bus.phase, bus.perm_start, bus.perm_rounds, bus.load_key);
          end
        end
        6: begin
          checks++;
          if ({bus.phase, bus.tag_valid} !== {3'd5, 1'b1}) begin
            errors++;
            $display("FAIL min_c6: phase %0d tag %0d expected 5 1", bus.phase, bus.tag_valid);
          end
        end
        7: begin
          checks++;
          if ({bus.phase, bus.busy} !== {3'd0, 1'b0}) begin
            errors++;
            $display("FAIL min_c7: phase %0d busy %0d expected 0 0", bus.phase, bus.busy);
          end
        end
        default: ;
      endcase
    end
  endtask

  // One encryption checked against sequences derived from the block counts
  task automatic run_txn(input int ad, input int pt, input int dmax, input bit spur, input bit junk);
    int         ptn;
    int         er[$];
    logic [9:0] ee[$];
    int         n;
    bit         bad;
    ptn = (pt == 0) ? 1 : pt;
    er.push_back(A);
    repeat (ad) er.push_back(B);
    repeat (ptn - 1) er.push_back(B);
    er.push_back(A);
    for (int i = 0; i < ad; i++) ee.push_back({2'd0, 8'(i)});
    ee.push_back({2'd2, 8'd0});
    for (int i = 0; i < ptn; i++) ee.push_back({2'd1, 8'(i)});

    resp_min = 1;
    resp_max = dmax;
    spur_en  = spur;
    clear_mon();
    bus.ad_blocks = 8'(ad);
    bus.pt_blocks = 8'(pt);
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.phase !== 3'd1) begin
      errors++;
      $display("FAIL txn_init: phase %0d expected 1", bus.phase);
    end
    n = 0;
    while (bus.busy && n < 20000) begin
      if (junk) begin
        bus.start     = 1'($urandom_range(0, 1));
        bus.ad_blocks = 8'($urandom);
        bus.pt_blocks = 8'($urandom);
      end
      tick();
      n++;
    end
    bus.start = 1'b0;
    checks++;
    if (n >= 20000) begin
      errors++;
      $display("FAIL txn_timeout: cycles %0d expected below 20000", n);
    end
    tick();
    tick();
    spur_en = 1'b0;
    checks++;
    if (bus.phase !== 3'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL txn_idle_after: phase %0d busy %0d expected 0 0", bus.phase, bus.busy);
    end

    bad = (q_rounds.size() != er.size());
    if (!bad) foreach (er[i]) if (q_rounds[i] != er[i]) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL txn_rounds ad=%0d pt=%0d: got %0d launches expected %0d", ad, pt, q_rounds.size(), er.size());
    end

    bad = (q_ev.size() != ee.size());
    if (!bad) foreach (ee[i]) if (q_ev[i] !== ee[i]) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL txn_strobes ad=%0d pt=%0d: got %0d events expected %0d", ad, pt, q_ev.size(), ee.size());
    end

    checks++;
    if (n_load != 2 || n_tag != 1) begin
      errors++;
      $display("FAIL txn_key_tag: load_key %0d tag_valid %0d expected 2 1", n_load, n_tag);
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL txn_protocol: violations %0d expected 0", viol);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      run_txn(int'($urandom_range(0, 4)), int'($urandom_range(0, 5)),
              int'($urandom_range(1, 4)), 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_txn(2, 3, 1, 1'b0, 1'b0);
    run_txn(1, 2, 3, 1'b1, 1'b1);
  endtask

  task automatic test_boundary();
    run_txn(0, 0, 2, 1'b1, 1'b1);
    run_txn(3, 0, 1, 1'b1, 1'b0);
    run_txn(255, 255, 1, 1'b0, 1'b0);
  endtask

  task automatic test_rst_mid();
    int  n;
    bit  quiet;
    resp_min = 3;
    resp_max = 3;
    spur_en  = 1'b0;
    clear_mon();
    bus.ad_blocks = 8'd1;
    bus.pt_blocks = 8'd3;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (!(bus.phase == 3'd3 && bus.perm_start) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL rst_mid_reach_pt: cycles %0d expected below 200", n);
    end
    rst = 1'b1;
    bus.start = 1'b1;
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    clear_mon();
    quiet = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (out_vec() !== 27'd0) quiet = 1'b0;
      tick();
    end
    checks++;
    if (!quiet || n_strobe != 0) begin
      errors++;
      $display("FAIL rst_mid_quiet: strobes %0d outputs %h expected 0 0", n_strobe, out_vec());
    end
    run_txn(1, 1, 1, 1'b0, 1'b0);
  endtask

`ifdef ASCON_ABORT_EN
  task automatic test_abort();
    int n;
    bus.abort = 1'b1;
    resp_min  = 1;
    resp_max  = 2;
    clear_mon();
    bus.ad_blocks = 8'd1;
    bus.pt_blocks = 8'd1;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checks++;
    if (bus.phase !== 3'd1) begin
      errors++;
      $display("FAIL abort_idle_noeffect: phase %0d expected 1", bus.phase);
    end
    n = 0;
    while (bus.phase != 3'd4 && n < 200) begin
      tick();
      n++;
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++;
    if (out_vec() !== 27'd0) begin
      errors++;
      $display("FAIL abort_final: got %h expected 0", out_vec());
    end
    repeat (4) tick();
    checks++;
    if (n_tag != 0) begin
      errors++;
      $display("FAIL abort_no_tag: tag_valid %0d expected 0", n_tag);
    end
    run_txn(2, 2, 2, 1'b1, 1'b0);
  endtask
`endif

  initial begin
    bus.start     = 1'b0;
    bus.ad_blocks = 8'd0;
    bus.pt_blocks = 8'd0;
`ifdef ASCON_ABORT_EN
    bus.abort     = 1'b0;
`endif
    clear_mon();
    test_reset();
    test_minimal();
    test_random();
    test_back_to_back();
    test_boundary();
    test_rst_mid();
`ifdef ASCON_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ascon_phase_ctrl.md
ASCON_PHASE_CTRL -- requirements
Module: ascon_phase_ctrl

Interface
- REQ-001: Parameter A, default 12: rounds for the initialization and finalization permutations (1..15).
- REQ-002: Parameter B, default 6: rounds for the intermediate AD and PT permutations (1..15).
- REQ-003: clk  in  1  sole clock; all state changes on its rising edge.
- REQ-004: rst  in  1  synchronous, active-high reset.
- REQ-005: start  in  1  request one encryption; sampled only in IDLE.
- REQ-006: ad_blocks  in  8  number of AD blocks; latched when start is accepted.
- REQ-007: pt_blocks  in  8  number of PT blocks; latched when start is accepted.
- REQ-008: perm_ready  in  1  one-cycle pulse from the permutation core marking completion.
- REQ-009: perm_start  out  1  one-cycle pulse launching the permutation core.
- REQ-010: perm_rounds  out  4  round count for the current launch; valid while perm_start=1.
- REQ-011: phase  out  3  current phase: IDLE=0, INIT=1, AD=2, PT=3, FINAL=4, TAG=5.
- REQ-012: blk_idx  out  8  index of the current AD or PT block.
- REQ-013: load_key, absorb_ad, absorb_pt, dom_sep, tag_valid  out  1 each  one-cycle datapath strobes.
- REQ-014: busy  out  1  high in every phase except IDLE.

Function
- REQ-015: All outputs SHALL be registered.
- REQ-016: Each strobe and perm_start SHALL be high for exactly one cycle per event.
- REQ-017: IDLE: start=1 SHALL latch ad_blocks and pt_blocks (pt_blocks=0 treated as 1). The next cycle SHALL be INIT, with load_key=1, perm_start=1 and perm_rounds=A.
- REQ-018: At most one permutation SHALL be outstanding. After perm_start, the FSM SHALL hold until perm_ready.
- REQ-019: perm_ready with no permutation outstanding SHALL be ignored.
- REQ-020: INIT + perm_ready, ad_blocks>0: the next cycle SHALL be AD with blk_idx=0, absorb_ad=1, perm_start=1 and perm_rounds=B.
- REQ-021: INIT + perm_ready, ad_blocks=0: the next cycle SHALL be PT with blk_idx=0 and dom_sep=1.
- REQ-022: AD + perm_ready, blk_idx<ad_blocks-1: SHALL increment blk_idx, then pulse absorb_ad and perm_start (rounds B).
- REQ-023: AD + perm_ready on the last AD block: the next cycle SHALL be PT with blk_idx=0 and dom_sep=1.
- REQ-024: PT, non-last block: SHALL pulse absorb_pt, perm_start and perm_rounds=B in the cycle the block is presented, wait for perm_ready, then increment blk_idx.
- REQ-025: PT, last block: SHALL pulse absorb_pt without perm_start. The next cycle SHALL be FINAL with perm_start=1, perm_rounds=A and load_key=1.
- REQ-026: FINAL + perm_ready: the next cycle SHALL be TAG with tag_valid=1. The cycle after SHALL be IDLE with busy=0.
- REQ-027: start while busy=1 SHALL be ignored and not queued.
- REQ-028: start in the same cycle the FSM returns to IDLE SHALL be ignored. start is accepted only while phase=IDLE.
- REQ-029: blk_idx SHALL never wrap: ad_blocks=255 and pt_blocks=255 are legal, and the maximum index is 254.
- REQ-030: perm_rounds SHALL read 0 whenever perm_start=0.

Reset
- REQ-031: rst=1 SHALL, on the next edge, force phase=IDLE, blk_idx=0, busy=0, all strobes=0, perm_rounds=0 and the latched counts=0.
- REQ-032: rst SHALL take priority over all inputs, including start and perm_ready in the same cycle.
- REQ-033: rst mid-operation SHALL abandon the outstanding permutation, and a perm_ready arriving after reset SHALL be ignored.

Configuration
- REQ-034: Macro ASCON_ABORT_EN defined: SHALL add input abort (1 bit). abort=1 in any non-IDLE phase SHALL return to IDLE next cycle with all outputs at reset values and no tag_valid. abort in IDLE SHALL have no effect.
- REQ-035: ASCON_ABORT_EN undefined: the abort port SHALL NOT exist, and the behaviour SHALL be identical to REQ-015..REQ-033.

Verification
- REQ-036: Minimal run: A=12, B=6, ad_blocks=0, pt_blocks=1, perm_ready 1 cycle after each perm_start, start at cycle 0. Required sequence:
  - cycle 1: load_key, perm_start(12)
  - cycle 3: PT, dom_sep, absorb_pt
  - cycle 4: FINAL, perm_start(12)
  - cycle 6: tag_valid
  - cycle 7: busy=0
- REQ-037: ad_blocks=2, pt_blocks=3: perm_rounds sequence SHALL be 12,6,6,6,6,12. Counts: absorb_ad ×2, absorb_pt ×3, dom_sep ×1, tag_valid ×1.
- REQ-038: pt_blocks=0: behaviour SHALL match pt_blocks=1 (one absorb_pt, no B-round permutation).
- REQ-039: start pulsed during AD and in the TAG cycle -> SHALL be ignored. Exactly one tag_valid; phase=IDLE afterwards.
- REQ-040: rst asserted in PT with a permutation outstanding, then perm_ready 2 cycles later -> SHALL stay IDLE with no strobes.
- REQ-041: ASCON_ABORT_EN defined, abort in FINAL -> SHALL reach IDLE next cycle with no tag_valid. A subsequent start SHALL complete normally.
